// File: rtl/vga_framebuffer_reader_if.sv
// Signal bundle between the VGA framebuffer reader, the frame RAM read port and
// the display pins. The reader side is the master.
interface vga_framebuffer_reader_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] DP_RAM_addr_out;
  logic [7:0]        DP_RAM_data_out;
  logic [3:0]        VGA_R;
  logic [3:0]        VGA_G;
  logic [3:0]        VGA_B;
  logic              VGA_HS;
  logic              VGA_VS;
  logic              FRAME_START;

  modport master (
    output DP_RAM_addr_out,
    input  DP_RAM_data_out,
    output VGA_R,
    output VGA_G,
    output VGA_B,
    output VGA_HS,
    output VGA_VS,
    output FRAME_START
  );

  modport slave (
    input  DP_RAM_addr_out,
    output DP_RAM_data_out,
    input  VGA_R,
    input  VGA_G,
    input  VGA_B,
    input  VGA_HS,
    input  VGA_VS,
    input  FRAME_START
  );
endinterface

// File: rtl/vga_framebuffer_reader.sv
// 640x480 VGA scan-out of a 320x240 RGB332 frame RAM with 2x2 pixel upscale.
// Three-stage pipeline: counters -> RAM address -> RAM data -> RGB444 pins.
module vga_framebuffer_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ADDR_W   = 17
) (
  input logic                      CLK,
  input logic                      RSTN,
  vga_framebuffer_reader_if.master vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W     = $clog2(H_TOTAL);
  localparam int VC_W     = $clog2(V_TOTAL);
  localparam int X_W      = $clog2(IMG_W);
  localparam int Y_W      = $clog2(IMG_H);
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic              run;
  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  ctrl_t             ctrl0;
  ctrl_t             ctrl1;
  ctrl_t             ctrl2;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr0;

  // run holds the counters at 0,0 through the first edge after reset, so the
  // frame (and FRAME_START three clocks later) begins on that edge.
  always_ff @(posedge CLK or negedge RSTN) begin
    // NOTE: state is assigned with <= so every register samples pre-edge values.
    if (!RSTN) begin
      run <= 1'b0;
      hc  <= '0;
      vc  <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (hc == HC_W'(H_TOTAL - 1)) begin
          hc <= '0;
          vc <= (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: all outputs of this block are defaulted first so no path infers a latch.
    ctrl0    = CTRL_IDLE;
    x        = X_W'(hc >> 1);
    y        = Y_W'(vc >> 1);
    row_base = '0;
    addr0    = '0;

    ctrl0.active = run && (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
    ctrl0.hs     = !((hc >= HC_W'(HS_FIRST)) && (hc <= HC_W'(HS_LAST)));
    ctrl0.vs     = !((vc >= VC_W'(VS_FIRST)) && (vc <= VC_W'(VS_LAST)));
    ctrl0.fs     = run && (hc == '0) && (vc == '0);

    // y*IMG_W as a sum of shifted copies of y; for 320 this is (y<<8)+(y<<6).
    for (int b = 0; b < ADDR_W; b++) begin
      if (IMG_W[b]) row_base = row_base + (ADDR_W'(y) << b);
    end

    if (ctrl0.active) addr0 = row_base + ADDR_W'(x);
  end

  // Stage 1 drives the RAM address; stage 2 waits out the RAM read latency.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vga.DP_RAM_addr_out <= '0;
      ctrl1               <= CTRL_IDLE;
      ctrl2               <= CTRL_IDLE;
    end else begin
      vga.DP_RAM_addr_out <= addr0;
      ctrl1               <= ctrl0;
      ctrl2               <= ctrl1;
    end
  end

  // Stage 3: RGB332 to RGB444 by replicating the top bits; blanking forces black.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vga.VGA_R       <= '0;
      vga.VGA_G       <= '0;
      vga.VGA_B       <= '0;
      vga.VGA_HS      <= 1'b1;
      vga.VGA_VS      <= 1'b1;
      vga.FRAME_START <= 1'b0;
    end else begin
      vga.VGA_HS      <= ctrl2.hs;
      vga.VGA_VS      <= ctrl2.vs;
      vga.FRAME_START <= ctrl2.fs;
      if (ctrl2.active) begin
        vga.VGA_R <= {vga.DP_RAM_data_out[7:5], vga.DP_RAM_data_out[7]};
        vga.VGA_G <= {vga.DP_RAM_data_out[4:2], vga.DP_RAM_data_out[4]};
        vga.VGA_B <= {vga.DP_RAM_data_out[1:0], vga.DP_RAM_data_out[1:0]};
      end else begin
        vga.VGA_R <= '0;
        vga.VGA_G <= '0;
        vga.VGA_B <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Scoreboard bench for vga_framebuffer_reader: full horizontal timing, shortened
// vertical timing so several whole frames fit in a short run.
module tb_vga_framebuffer_reader;
  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_ACT  = 8;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = 17;
  localparam int FRAME  = H_TOT * V_TOT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } pix_t;

  localparam pix_t PIX_IDLE = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic clk;
  logic rst_n;
  logic       ram_fixed_en;
  logic [7:0] ram_fixed;

  int n_asserts;
  int n_fail;
  int hc_m;
  int vc_m;
  int cyc;
  logic prev_hs;
  logic prev_vs;

  logic [ADDR_W-1:0] addr_q[$];
  pix_t              pix_q[$];
  int fs_q[$];
  int hs_fall_q[$];
  int hs_len_q[$];
  int vs_fall_q[$];
  int vs_len_q[$];

  vga_framebuffer_reader_if #(.ADDR_W(ADDR_W)) vga ();

  vga_framebuffer_reader #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .vga  (vga)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Synchronous RAM model: data for the registered address one clock later.
  always @(posedge clk)
    vga.DP_RAM_data_out <= ram_fixed_en ? ram_fixed : vga.DP_RAM_addr_out[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_addr(input int hc, input int vc);
    if (hc < H_ACT && vc < V_ACT) return (vc / 2) * IMG_W + hc / 2;
    return 0;
  endfunction

  function automatic pix_t model_pix(input int hc, input int vc,
                                     input logic fixed_en, input logic [7:0] fixed);
    pix_t p;
    int   r3, g3, b2;
    logic [7:0] d;
    p.hs  = !((hc >= H_ACT + H_FP) && (hc < H_ACT + H_FP + H_SYNC));
    p.vs  = !((vc >= V_ACT + V_FP) && (vc < V_ACT + V_FP + V_SYNC));
    p.fs  = (hc == 0) && (vc == 0);
    p.rgb = 12'h000;
    if (hc < H_ACT && vc < V_ACT) begin
      d  = fixed_en ? fixed : 8'(model_addr(hc, vc));
      r3 = int'(d[7:5]);
      g3 = int'(d[4:2]);
      b2 = int'(d[1:0]);
      p.rgb = {4'(r3 * 2 + r3 / 4), 4'(g3 * 2 + g3 / 4), 4'(b2 * 5)};
    end
    return p;
  endfunction

  // Prefilled entries stand for the idle pipeline contents right after reset.
  task automatic sb_reset();
    addr_q.delete();
    pix_q.delete();
    addr_q.push_back('0);
    repeat (3) pix_q.push_back(PIX_IDLE);
    hc_m = 0;
    vc_m = 0;
    cyc  = 0;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    fs_q.delete();
    hs_fall_q.delete();
    hs_len_q.delete();
    vs_fall_q.delete();
    vs_len_q.delete();
  endtask

  task automatic cycle();
    logic [ADDR_W-1:0] ea;
    pix_t              ep;
    @(negedge clk);
    addr_q.push_back(ADDR_W'(model_addr(hc_m, vc_m)));
    pix_q.push_back(model_pix(hc_m, vc_m, ram_fixed_en, ram_fixed));
    ea = addr_q.pop_front();
    ep = pix_q.pop_front();
    check("addr", vga.DP_RAM_addr_out, ea);
    check("rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, ep.rgb);
    check("hs", vga.VGA_HS, ep.hs);
    check("vs", vga.VGA_VS, ep.vs);
    check("frame_start", vga.FRAME_START, ep.fs);

    if (cyc == 3) check("second_pair_addr", vga.DP_RAM_addr_out, 1);
    if (cyc == H_ACT + 1) check("blank_addr_after_639", vga.DP_RAM_addr_out, 0);
    if (cyc == 2 * H_TOT + 1) check("line2_first_addr", vga.DP_RAM_addr_out, IMG_W);
    if (cyc == (V_ACT - 1) * H_TOT + H_ACT)
      check("last_pixel_addr", vga.DP_RAM_addr_out, (V_ACT / 2 - 1) * IMG_W + IMG_W - 1);
    if (!ram_fixed_en && cyc == 2 * 8'hE3 + 3)
      check("rgb_e3", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 12'hF0F);
    if (!ram_fixed_en && cyc == 2 * 8'h1C + 3)
      check("rgb_1c", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 12'h0F0);

    if (vga.FRAME_START === 1'b1) fs_q.push_back(cyc);
    if (prev_hs === 1'b1 && vga.VGA_HS === 1'b0) hs_fall_q.push_back(cyc);
    if (prev_hs === 1'b0 && vga.VGA_HS === 1'b1 && hs_fall_q.size() > 0)
      hs_len_q.push_back(cyc - hs_fall_q[$]);
    if (prev_vs === 1'b1 && vga.VGA_VS === 1'b0) vs_fall_q.push_back(cyc);
    if (prev_vs === 1'b0 && vga.VGA_VS === 1'b1 && vs_fall_q.size() > 0)
      vs_len_q.push_back(cyc - vs_fall_q[$]);
    prev_hs = vga.VGA_HS;
    prev_vs = vga.VGA_VS;

    hc_m++;
    if (hc_m == H_TOT) begin
      hc_m = 0;
      vc_m = (vc_m == V_TOT - 1) ? 0 : vc_m + 1;
    end
    cyc++;
  endtask

  // Runs at least one clock, then stops once the model's next state is (hc_t, vc_t).
  task automatic run_until(input int hc_t, input int vc_t, input int budget);
    int steps;
    steps = 0;
    do begin
      cycle();
      steps++;
    end while (!(hc_m == hc_t && vc_m == vc_t) && steps < budget);
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_addr"}, vga.DP_RAM_addr_out, 0);
    check({phase, "_rgb"}, {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 12'h000);
    check({phase, "_hs"}, vga.VGA_HS, 1'b1);
    check({phase, "_vs"}, vga.VGA_VS, 1'b1);
    check({phase, "_frame_start"}, vga.FRAME_START, 1'b0);
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    cyc          = 0;
    ram_fixed_en = 1'b1;
    ram_fixed    = 8'hFF;
    rst_n        = 1'b0;

    // Power-on reset with RAM data high: pins must still show reset values.
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    // Frame 0: RAM returns addr[7:0]; frame 1: data 00; frame 2: data FF.
    ram_fixed_en = 1'b0;
    rst_n        = 1'b1;
    sb_reset();
    run_until(0, V_ACT + 1, 2 * FRAME);
    ram_fixed    = 8'h00;
    ram_fixed_en = 1'b1;
    run_until(0, V_ACT + 1, 2 * FRAME);
    ram_fixed    = 8'hFF;
    run_until(300, 5, 2 * FRAME);

    check("fs_count", fs_q.size(), 3);
    check("fs_first", fs_q[0], 3);
    check("fs_period_0", fs_q[1] - fs_q[0], FRAME);
    check("fs_period_1", fs_q[2] - fs_q[1], FRAME);
    check("hs_first_fall", hs_fall_q[0], H_ACT + H_FP + 3);
    check("hs_period", hs_fall_q[1] - hs_fall_q[0], H_TOT);
    foreach (hs_len_q[i]) check("hs_width", hs_len_q[i], H_SYNC);
    check("vs_first_fall", vs_fall_q[0], (V_ACT + V_FP) * H_TOT + 3);
    check("vs_width", vs_len_q[0], V_SYNC * H_TOT);
    check("vs_period", vs_fall_q[1] - vs_fall_q[0], FRAME);

    // Mid-frame reset while the pins show active FF pixels.
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_reset();
    repeat (FRAME + 10) cycle();

    check("restart_fs_count", fs_q.size(), 2);
    check("restart_fs_first", fs_q[0], 3);
    check("restart_fs_period", fs_q[1] - fs_q[0], FRAME);
    check("restart_hs_first_fall", hs_fall_q[0], H_ACT + H_FP + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
